pcs_loopback_ctrl: RTL and testbench
====================================

Name: pcs_loopback_ctrl

Overview:
- Sequences the RX->TX PCS loopback path after the transceiver reset controller reports ready.
- Holds the PCS TX in reset until the RX path is stable, then fills idles.
- Switches to word forwarding only on a frame boundary.
- Reacts to signal loss by terminating any open frame with an error word and re-acquiring.
- Sits in the core logic clock domain, between the PCS RX outputs and the PCS TX inputs.

Parameters:
IS_10G, 1, 1: 10G (2 start lanes); 0: 1 start lane
DATA_W, 64, data width
KEEP_W, DATA_W/8, keep width
LOCK_CYCLES, 64, consecutive rx_signal_v_i cycles needed before TX reset release
IDLE_CYCLES, 16, minimum idle words sent before forwarding
CNT_W, 16, statistics counter width

Ports:
clk  in  1  core logic clock
nreset  in  1  asynchronous active-low reset
serdes_ready_i  in  1  transceiver RX and TX ready, already synchronised to clk
rx_signal_v_i  in  1  PCS RX block lock
rx_valid_i  in  1  RX word valid
rx_ctrl_v_i / rx_idle_v_i / rx_term_v_i / rx_err_v_i  in  1 each  RX control flags
rx_start_v_i  in  LANE0_CNT_N  start flags; LANE0_CNT_N = IS_10G ? 2 : 1
rx_data_i  in  DATA_W  RX data
rx_keep_i  in  KEEP_W  RX byte keep
tx_ready_i  in  1  PCS TX accepts input this cycle
tx_nreset_o  out  1  PCS TX active-low reset
tx_ctrl_v_o / tx_idle_v_o / tx_term_v_o / tx_err_v_o  out  1 each  TX control flags
tx_start_v_o  out  LANE0_CNT_N  TX start flags
tx_data_o  out  DATA_W  TX data
tx_keep_o  out  KEEP_W  TX byte keep
state_o  out  3  current FSM state
drop_cnt_o  out  CNT_W  dropped or underrun word count
relock_cnt_o  out  CNT_W  signal-loss event count

Behaviour:
- Reset values: tx_nreset_o=0; state_o=WAIT_SERDES; counters=0; all TX outputs idle word.
- Idle word: ctrl=1, idle=1, start/term/err=0, data=0, keep=0.
- Error word: ctrl=1, err=1, idle/start/term=0, data=0, keep=0.
- All outputs are registered.
- FSM encodings:
  - WAIT_SERDES (0): stay until serdes_ready_i=1.
  - WAIT_LOCK (1): lock counter increments while rx_signal_v_i=1 and clears to 0 when it drops. When the counter reaches LOCK_CYCLES-1 with rx_signal_v_i=1, go to IDLE_FILL and set tx_nreset_o=1 on the same edge.
  - IDLE_FILL (2): emit idle words. The fill counter increments on each cycle with tx_ready_i=1 and saturates at IDLE_CYCLES. Go to FORWARD when fill >= IDLE_CYCLES, rx_valid_i=1, rx_idle_v_i=1 and tx_ready_i=1; that idle word is the first one forwarded.
  - FORWARD (3): when tx_ready_i=1 and rx_valid_i=1, register the RX word onto the TX outputs (1-cycle latency).
- in_frame flag:
  - Set on a forwarded word with any start bit.
  - Cleared on a forwarded word with term or err.
  - If both start and term occur in one word, the flag ends at start-after-term order: set when any start bit is at a higher lane index than the term position. In practice, 10G lane-1 start after term sets the flag; otherwise the flag is cleared.
- FORWARD, tx_ready_i=0:
  - TX outputs hold.
  - A valid idle RX word is deleted silently.
  - A valid non-idle RX word increments drop_cnt.
- FORWARD, tx_ready_i=1 and rx_valid_i=0:
  - If in_frame: emit error word, clear in_frame, increment drop_cnt.
  - Otherwise: emit idle word.
- Signal loss (rx_signal_v_i=0 in IDLE_FILL or FORWARD):
  - If in_frame: emit error word once, then idle words.
  - Always: go to WAIT_LOCK, increment relock_cnt, clear the fill counter, keep tx_nreset_o=1.
- serdes_ready_i=0 in any state other than WAIT_SERDES:
  - Go to WAIT_SERDES, tx_nreset_o=0, TX outputs become the idle word.
  - relock_cnt is not incremented.
  - Takes priority over signal loss.
- All counters saturate at all-ones.
- Asynchronous nreset mid-operation returns everything to reset values immediately.

Optional Feature:
- Macro: PCS_LOOPBACK_STATS_EN.
- Defined: drop_cnt_o and relock_cnt_o count as specified above.
- Undefined: counter flops are not built and both ports are tied to 0. All other behaviour is unchanged.

Test Plan:
- Reset, serdes_ready_i=1, rx_signal_v_i=1 held:
  - tx_nreset_o rises after the FSM has spent exactly 64 cycles in WAIT_LOCK.
  - state goes 0->1->2.
- Lock glitch at cycle 40 of WAIT_LOCK -> counter restarts; release happens 64 cycles after the glitch ends.
- IDLE_FILL with RX mid-frame data (non-idle) after 16 fill cycles:
  - Stays in IDLE_FILL until the first RX idle.
  - The next RX start word appears on TX exactly 1 cycle after input.
- Forward a start + 3 data + term frame with tx_ready_i=0 on the data-2 cycle:
  - drop_cnt=1, TX holds data-1.
  - Repeat with an idle on the ready-low cycle -> drop_cnt stays 0.
- rx_signal_v_i=0 after start + 1 data word:
  - Exactly one error word, then idles.
  - relock_cnt=1, state=1, tx_nreset_o stays 1.
- serdes_ready_i=0 during FORWARD -> next cycle tx_nreset_o=0, state=0, relock_cnt unchanged.
- With PCS_LOOPBACK_STATS_EN undefined, both counter ports read 0.

Source files
------------

// File: rtl/pcs_loopback_ctrl.sv
// -----------------------------------------------------------------------------
// pcs_loopback_ctrl
//   Sequences the RX->TX PCS loopback path. After the transceiver reports
//   ready it waits for a stable RX block lock, releases the PCS TX reset and
//   sends idle words. It moves to word forwarding only on an RX idle, so it
//   always joins the stream on a frame boundary. If the RX lock drops, any
//   open frame is closed with an error word and lock is acquired again.
//
//   Optional feature macro: PCS_LOOPBACK_STATS_EN
//     defined   : drop_cnt_o / relock_cnt_o are saturating event counters
//     undefined : no counter flops, both ports tied to 0
//
// Ports
//   clk, nreset              core clock, asynchronous active-low reset
//   serdes_ready_i           transceiver RX+TX ready (already in clk domain)
//   rx_signal_v_i            PCS RX block lock
//   rx_valid_i               RX word valid
//   rx_ctrl/idle/term/err_v_i, rx_start_v_i[LANE0_CNT_N]  RX control flags
//   rx_data_i, rx_keep_i     RX word payload
//   tx_ready_i               PCS TX accepts a word this cycle
//   tx_nreset_o              PCS TX active-low reset
//   tx_ctrl/idle/term/err_v_o, tx_start_v_o, tx_data_o, tx_keep_o  TX word
//   state_o                  FSM state (0 WAIT_SERDES, 1 WAIT_LOCK,
//                            2 IDLE_FILL, 3 FORWARD)
//   drop_cnt_o               dropped or underrun word count
//   relock_cnt_o             signal-loss event count
// -----------------------------------------------------------------------------
module pcs_loopback_ctrl #(
    parameter int IS_10G      = 1,
    parameter int DATA_W      = 64,
    parameter int KEEP_W      = DATA_W / 8,
    parameter int LOCK_CYCLES = 64,
    parameter int IDLE_CYCLES = 16,
    parameter int CNT_W       = 16
) (
    input  logic                                clk,
    input  logic                                nreset,
    input  logic                                serdes_ready_i,
    input  logic                                rx_signal_v_i,
    input  logic                                rx_valid_i,
    input  logic                                rx_ctrl_v_i,
    input  logic                                rx_idle_v_i,
    input  logic                                rx_term_v_i,
    input  logic                                rx_err_v_i,
    input  logic [((IS_10G != 0) ? 2 : 1)-1:0]  rx_start_v_i,
    input  logic [DATA_W-1:0]                   rx_data_i,
    input  logic [KEEP_W-1:0]                   rx_keep_i,
    input  logic                                tx_ready_i,
    output logic                                tx_nreset_o,
    output logic                                tx_ctrl_v_o,
    output logic                                tx_idle_v_o,
    output logic                                tx_term_v_o,
    output logic                                tx_err_v_o,
    output logic [((IS_10G != 0) ? 2 : 1)-1:0]  tx_start_v_o,
    output logic [DATA_W-1:0]                   tx_data_o,
    output logic [KEEP_W-1:0]                   tx_keep_o,
    output logic [2:0]                          state_o,
    output logic [CNT_W-1:0]                    drop_cnt_o,
    output logic [CNT_W-1:0]                    relock_cnt_o
);

    localparam int LANE0_CNT_N = (IS_10G != 0) ? 2 : 1;
    localparam int LOCK_W      = $clog2(LOCK_CYCLES + 1);
    localparam int FILL_W      = (IDLE_CYCLES > 0) ? $clog2(IDLE_CYCLES + 1) : 1;

    typedef enum logic [2:0] {
        WAIT_SERDES = 3'd0,
        WAIT_LOCK   = 3'd1,
        IDLE_FILL   = 3'd2,
        FORWARD     = 3'd3
    } state_e;

    typedef struct packed {
        logic                   ctrl;
        logic                   idle;
        logic                   term;
        logic                   err;
        logic [LANE0_CNT_N-1:0] start;
        logic [DATA_W-1:0]      data;
        logic [KEEP_W-1:0]      keep;
    } pcs_word_t;

    function automatic pcs_word_t idle_word();
        pcs_word_t w;
        w      = '0;
        w.ctrl = 1'b1;
        w.idle = 1'b1;
        return w;
    endfunction

    function automatic pcs_word_t err_word();
        pcs_word_t w;
        w      = '0;
        w.ctrl = 1'b1;
        w.err  = 1'b1;
        return w;
    endfunction

    state_e             state_q, state_d;
    logic [LOCK_W-1:0]  lock_q, lock_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               in_frame_q, in_frame_d;
    logic               tx_nreset_q, tx_nreset_d;
    pcs_word_t          tx_q, tx_d;
    pcs_word_t          rx_w;
    logic               drop_inc;
    logic               relock_inc;

    always_comb begin
        rx_w       = '0;
        rx_w.ctrl  = rx_ctrl_v_i;
        rx_w.idle  = rx_idle_v_i;
        rx_w.term  = rx_term_v_i;
        rx_w.err   = rx_err_v_i;
        rx_w.start = rx_start_v_i;
        rx_w.data  = rx_data_i;
        rx_w.keep  = rx_keep_i;
    end

    always_comb begin
        state_d     = state_q;
        lock_d      = lock_q;
        fill_d      = fill_q;
        in_frame_d  = in_frame_q;
        tx_nreset_d = tx_nreset_q;
        tx_d        = tx_q;
        drop_inc    = 1'b0;
        relock_inc  = 1'b0;

        case (state_q)
            WAIT_SERDES: begin
                tx_nreset_d = 1'b0;
                tx_d        = idle_word();
                if (serdes_ready_i) state_d = WAIT_LOCK;
            end

            WAIT_LOCK: begin
                // A pending error word from a signal loss is held until the
                // PCS takes it, then idles follow.
                if (tx_ready_i) tx_d = idle_word();
                if (!rx_signal_v_i) begin
                    lock_d = '0;
                end else if (lock_q == LOCK_W'(LOCK_CYCLES - 1)) begin
                    state_d     = IDLE_FILL;
                    tx_nreset_d = 1'b1;
                end else begin
                    lock_d = lock_q + LOCK_W'(1);
                end
            end

            IDLE_FILL: begin
                if (tx_ready_i) begin
                    tx_d = idle_word();
                    if (fill_q != FILL_W'(IDLE_CYCLES)) fill_d = fill_q + FILL_W'(1);
                end
                if (!rx_signal_v_i) begin
                    state_d    = WAIT_LOCK;
                    relock_inc = 1'b1;
                end else if (fill_q >= FILL_W'(IDLE_CYCLES) && rx_valid_i &&
                             rx_idle_v_i && tx_ready_i) begin
                    // Joining on an RX idle guarantees a frame boundary.
                    state_d = FORWARD;
                    tx_d    = rx_w;
                end
            end

            FORWARD: begin
                if (!rx_signal_v_i) begin
                    state_d    = WAIT_LOCK;
                    relock_inc = 1'b1;
                    tx_d       = in_frame_q ? err_word() : idle_word();
                end else if (!tx_ready_i) begin
                    // TX holds; idles are rate-matching filler and may vanish.
                    if (rx_valid_i && !rx_idle_v_i) drop_inc = 1'b1;
                end else if (rx_valid_i) begin
                    tx_d = rx_w;
                    if (rx_term_v_i || rx_err_v_i) begin
                        // Only a 10G lane-1 start can follow a term in the
                        // same word; that opens the next frame.
                        in_frame_d = (LANE0_CNT_N == 2) && rx_term_v_i && !rx_err_v_i &&
                                     rx_start_v_i[LANE0_CNT_N-1];
                    end else if (|rx_start_v_i) begin
                        in_frame_d = 1'b1;
                    end
                end else if (in_frame_q) begin
                    // Underrun inside a frame: poison it rather than stall.
                    tx_d       = err_word();
                    in_frame_d = 1'b0;
                    drop_inc   = 1'b1;
                end else begin
                    tx_d = idle_word();
                end
            end

            default: begin
                state_d     = WAIT_SERDES;
                tx_nreset_d = 1'b0;
                tx_d        = idle_word();
            end
        endcase

        // Transceiver loss overrides everything, including signal loss.
        if (state_q != WAIT_SERDES && !serdes_ready_i) begin
            state_d     = WAIT_SERDES;
            tx_nreset_d = 1'b0;
            tx_d        = idle_word();
            drop_inc    = 1'b0;
            relock_inc  = 1'b0;
        end

        // Per-state counters restart whenever their state is (re)entered.
        if (state_d != WAIT_LOCK) lock_d = '0;
        if (state_d != IDLE_FILL) fill_d = '0;
        if (state_d != FORWARD)   in_frame_d = 1'b0;
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= WAIT_SERDES;
            lock_q      <= '0;
            fill_q      <= '0;
            in_frame_q  <= 1'b0;
            tx_nreset_q <= 1'b0;
            tx_q        <= idle_word();
        end else begin
            state_q     <= state_d;
            lock_q      <= lock_d;
            fill_q      <= fill_d;
            in_frame_q  <= in_frame_d;
            tx_nreset_q <= tx_nreset_d;
            tx_q        <= tx_d;
        end
    end

`ifdef PCS_LOOPBACK_STATS_EN
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic [CNT_W-1:0] relock_cnt_q, relock_cnt_d;

    always_comb begin
        drop_cnt_d   = drop_cnt_q;
        relock_cnt_d = relock_cnt_q;
        if (drop_inc && drop_cnt_q != '1)     drop_cnt_d   = drop_cnt_q + CNT_W'(1);
        if (relock_inc && relock_cnt_q != '1) relock_cnt_d = relock_cnt_q + CNT_W'(1);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            drop_cnt_q   <= '0;
            relock_cnt_q <= '0;
        end else begin
            drop_cnt_q   <= drop_cnt_d;
            relock_cnt_q <= relock_cnt_d;
        end
    end

    assign drop_cnt_o   = drop_cnt_q;
    assign relock_cnt_o = relock_cnt_q;
`else
    logic unused_stats;
    assign unused_stats = drop_inc | relock_inc;
    assign drop_cnt_o   = '0;
    assign relock_cnt_o = '0;
`endif

    assign tx_nreset_o  = tx_nreset_q;
    assign tx_ctrl_v_o  = tx_q.ctrl;
    assign tx_idle_v_o  = tx_q.idle;
    assign tx_term_v_o  = tx_q.term;
    assign tx_err_v_o   = tx_q.err;
    assign tx_start_v_o = tx_q.start;
    assign tx_data_o    = tx_q.data;
    assign tx_keep_o    = tx_q.keep;
    assign state_o      = state_q;

endmodule

// File: tb/tb_pcs_loopback_ctrl.sv
// Bench for pcs_loopback_ctrl with default parameters (10G, 64-bit data).
// TX words are compared through a queue: expected word pushed when the RX
// stimulus is driven, popped after the clock edge that should register it.
module tb_pcs_loopback_ctrl;

    typedef logic [77:0] w_t;   // {ctrl, idle, term, err, start[1:0], data[63:0], keep[7:0]}

`ifdef PCS_LOOPBACK_STATS_EN
    localparam int STATS = 1;
`else
    localparam int STATS = 0;
`endif

    localparam w_t IDLE_W = {1'b1, 1'b1, 1'b0, 1'b0, 2'b00, 64'h0, 8'h0};
    localparam w_t ERR_W  = {1'b1, 1'b0, 1'b0, 1'b1, 2'b00, 64'h0, 8'h0};

    logic        clk = 1'b0;
    logic        nreset;
    logic        serdes_ready_i, rx_signal_v_i, rx_valid_i;
    logic        rx_ctrl_v_i, rx_idle_v_i, rx_term_v_i, rx_err_v_i;
    logic [1:0]  rx_start_v_i;
    logic [63:0] rx_data_i;
    logic [7:0]  rx_keep_i;
    logic        tx_ready_i;
    logic        tx_nreset_o, tx_ctrl_v_o, tx_idle_v_o, tx_term_v_o, tx_err_v_o;
    logic [1:0]  tx_start_v_o;
    logic [63:0] tx_data_o;
    logic [7:0]  tx_keep_o;
    logic [2:0]  state_o;
    logic [15:0] drop_cnt_o, relock_cnt_o;

    int n_chk  = 0;
    int n_pass = 0;
    w_t exp_q[$];

    pcs_loopback_ctrl dut (
        .clk(clk), .nreset(nreset),
        .serdes_ready_i(serdes_ready_i), .rx_signal_v_i(rx_signal_v_i),
        .rx_valid_i(rx_valid_i), .rx_ctrl_v_i(rx_ctrl_v_i), .rx_idle_v_i(rx_idle_v_i),
        .rx_term_v_i(rx_term_v_i), .rx_err_v_i(rx_err_v_i), .rx_start_v_i(rx_start_v_i),
        .rx_data_i(rx_data_i), .rx_keep_i(rx_keep_i), .tx_ready_i(tx_ready_i),
        .tx_nreset_o(tx_nreset_o), .tx_ctrl_v_o(tx_ctrl_v_o), .tx_idle_v_o(tx_idle_v_o),
        .tx_term_v_o(tx_term_v_o), .tx_err_v_o(tx_err_v_o), .tx_start_v_o(tx_start_v_o),
        .tx_data_o(tx_data_o), .tx_keep_o(tx_keep_o), .state_o(state_o),
        .drop_cnt_o(drop_cnt_o), .relock_cnt_o(relock_cnt_o)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic w_t mk(input logic c, input logic i, input logic t, input logic e,
                              input logic [1:0] s, input logic [63:0] d, input logic [7:0] k);
        return {c, i, t, e, s, d, k};
    endfunction

    function automatic w_t tx_obs();
        return {tx_ctrl_v_o, tx_idle_v_o, tx_term_v_o, tx_err_v_o, tx_start_v_o, tx_data_o, tx_keep_o};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_rx(input w_t w, input logic vld);
        rx_valid_i   = vld;
        rx_ctrl_v_i  = w[77];
        rx_idle_v_i  = w[76];
        rx_term_v_i  = w[75];
        rx_err_v_i   = w[74];
        rx_start_v_i = w[73:72];
        rx_data_i    = w[71:8];
        rx_keep_i    = w[7:0];
    endtask

    // Reset, then run with lock held and idles on RX until FORWARD is reached.
    task automatic bring_up(output bit ok);
        nreset = 1'b0; serdes_ready_i = 1'b1; rx_signal_v_i = 1'b1; tx_ready_i = 1'b1;
        drive_rx(IDLE_W, 1'b1);
        step();
        nreset = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (state_o == 3'd3) begin ok = 1'b1; break; end
        end
    endtask

    task automatic test_reset();
        nreset = 1'b0; serdes_ready_i = 1'b0; rx_signal_v_i = 1'b0; tx_ready_i = 1'b1;
        drive_rx(IDLE_W, 1'b0);
        step(); step();
        n_chk++; if (state_o !== 3'd0) $display("FAIL reset_state: got %0d want 0", state_o); else n_pass++;
        n_chk++; if (tx_nreset_o !== 1'b0) $display("FAIL reset_txn: got %b want 0", tx_nreset_o); else n_pass++;
        n_chk++; if (tx_obs() !== IDLE_W) $display("FAIL reset_word: got %h want %h", tx_obs(), IDLE_W); else n_pass++;
        n_chk++; if (drop_cnt_o !== 16'd0) $display("FAIL reset_drop: got %0d want 0", drop_cnt_o); else n_pass++;
        n_chk++; if (relock_cnt_o !== 16'd0) $display("FAIL reset_relock: got %0d want 0", relock_cnt_o); else n_pass++;
    endtask

    // Leaves the DUT in IDLE_FILL with non-idle RX data applied.
    task automatic test_lock();
        int  n1 = 0;
        bit  early = 1'b0;
        bit  saw2 = 1'b0;
        nreset = 1'b1; rx_signal_v_i = 1'b1;
        drive_rx(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h1111, 8'hFF), 1'b1);
        step();
        n_chk++; if (state_o !== 3'd0) $display("FAIL lock_wait_serdes: got %0d want 0", state_o); else n_pass++;
        serdes_ready_i = 1'b1;
        for (int i = 0; i < 200 && !saw2; i++) begin
            step();
            if (state_o == 3'd1) begin
                n1++;
                if (tx_nreset_o) early = 1'b1;
            end else if (state_o == 3'd2) begin
                saw2 = 1'b1;
            end
        end
        n_chk++; if (saw2 !== 1'b1) $display("FAIL lock_reach_fill: got %b want 1", saw2); else n_pass++;
        n_chk++; if (n1 != 64) $display("FAIL lock_cycles: got %0d want 64", n1); else n_pass++;
        n_chk++; if (early !== 1'b0) $display("FAIL lock_early_release: got %b want 0", early); else n_pass++;
        n_chk++; if (tx_nreset_o !== 1'b1) $display("FAIL lock_release: got %b want 1", tx_nreset_o); else n_pass++;
    endtask

    task automatic test_idle_fill();
        w_t s, e;
        for (int i = 0; i < 20; i++) begin
            drive_rx(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'hA000 + 64'(i), 8'hFF), 1'b1);
            step();
            n_chk++; if (state_o !== 3'd2) $display("FAIL fill_stay[%0d]: got %0d want 2", i, state_o); else n_pass++;
            n_chk++; if (tx_obs() !== IDLE_W) $display("FAIL fill_word[%0d]: got %h want %h", i, tx_obs(), IDLE_W); else n_pass++;
        end
        drive_rx(IDLE_W, 1'b1);
        exp_q.push_back(IDLE_W);
        step();
        e = exp_q.pop_front();
        n_chk++; if (state_o !== 3'd3) $display("FAIL fill_to_fwd: got %0d want 3", state_o); else n_pass++;
        n_chk++; if (tx_obs() !== e) $display("FAIL fill_first_idle: got %h want %h", tx_obs(), e); else n_pass++;
        s = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 64'hDEAD_BEEF_0123_4567, 8'hFF);
        drive_rx(s, 1'b1);
        exp_q.push_back(s);
        step();
        e = exp_q.pop_front();
        n_chk++; if (tx_obs() !== e) $display("FAIL fill_start_latency: got %h want %h", tx_obs(), e); else n_pass++;
    endtask

    task automatic test_fill_boundary();
        bit ok;
        int n2 = 0;
        nreset = 1'b0; serdes_ready_i = 1'b1; rx_signal_v_i = 1'b1; tx_ready_i = 1'b1;
        drive_rx(IDLE_W, 1'b1);
        step();
        nreset = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            step();
            if (state_o == 3'd2) n2++;
            if (state_o == 3'd3) begin ok = 1'b1; break; end
        end
        n_chk++; if (!ok || n2 != 17) $display("FAIL fill_boundary: got %0d cycles (ok=%b) want 17", n2, ok); else n_pass++;
    endtask

    task automatic test_glitch();
        int n = 0;
        nreset = 1'b0; serdes_ready_i = 1'b1; rx_signal_v_i = 1'b1; tx_ready_i = 1'b1;
        drive_rx(IDLE_W, 1'b1);
        step();
        nreset = 1'b1;
        step();
        n_chk++; if (state_o !== 3'd1) $display("FAIL glitch_enter: got %0d want 1", state_o); else n_pass++;
        for (int i = 0; i < 39; i++) step();
        rx_signal_v_i = 1'b0;
        step();
        n_chk++; if (state_o !== 3'd1 || tx_nreset_o !== 1'b0)
            $display("FAIL glitch_hold: got state %0d txn %b want 1/0", state_o, tx_nreset_o); else n_pass++;
        rx_signal_v_i = 1'b1;
        for (int i = 0; i < 200; i++) begin
            step();
            n++;
            if (tx_nreset_o) break;
        end
        n_chk++; if (n != 64 || tx_nreset_o !== 1'b1) $display("FAIL glitch_release: got %0d cycles want 64", n); else n_pass++;
    endtask

    task automatic test_ready_drop(input bit idle_on_low);
        bit ok;
        w_t rxw[6], ex[6], e, d1;
        bit rdy[6];
        bring_up(ok);
        n_chk++; if (!ok) $display("FAIL drop_bring_up: got timeout want FORWARD"); else n_pass++;
        d1     = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h0000_0000_0000_D001, 8'hFF);
        rxw[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 64'h5555_0000_0000_0000, 8'hFF); rdy[0] = 1; ex[0] = rxw[0];
        rxw[1] = d1;                                                                rdy[1] = 1; ex[1] = d1;
        rxw[2] = idle_on_low ? IDLE_W : mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'hD002, 8'hFF);
                                                                                    rdy[2] = 0; ex[2] = d1;
        rxw[3] = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'hD003, 8'hFF);                rdy[3] = 1; ex[3] = rxw[3];
        rxw[4] = mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b00, 64'hD004, 8'h0F);                rdy[4] = 1; ex[4] = rxw[4];
        rxw[5] = IDLE_W;                                                            rdy[5] = 1; ex[5] = IDLE_W;
        for (int i = 0; i < 6; i++) begin
            drive_rx(rxw[i], 1'b1);
            tx_ready_i = rdy[i];
            exp_q.push_back(ex[i]);
            step();
            e = exp_q.pop_front();
            n_chk++; if (tx_obs() !== e) $display("FAIL drop_word[%0d] idle=%0d: got %h want %h", i, idle_on_low, tx_obs(), e); else n_pass++;
        end
        n_chk++; if (drop_cnt_o !== 16'(idle_on_low ? 0 : STATS))
            $display("FAIL drop_cnt idle=%0d: got %0d want %0d", idle_on_low, drop_cnt_o, idle_on_low ? 0 : STATS); else n_pass++;
    endtask

    task automatic test_sig_loss();
        bit ok;
        w_t s, d, e;
        bring_up(ok);
        n_chk++; if (!ok) $display("FAIL loss_bring_up: got timeout want FORWARD"); else n_pass++;
        s = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 64'h7777, 8'hFF);
        d = mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'h8888, 8'hFF);
        drive_rx(s, 1'b1); exp_q.push_back(s); step();
        e = exp_q.pop_front();
        n_chk++; if (tx_obs() !== e) $display("FAIL loss_start: got %h want %h", tx_obs(), e); else n_pass++;
        drive_rx(d, 1'b1); exp_q.push_back(d); step();
        e = exp_q.pop_front();
        n_chk++; if (tx_obs() !== e) $display("FAIL loss_data: got %h want %h", tx_obs(), e); else n_pass++;
        rx_signal_v_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(i == 0 ? ERR_W : IDLE_W);
            step();
            e = exp_q.pop_front();
            n_chk++; if (tx_obs() !== e) $display("FAIL loss_word[%0d]: got %h want %h", i, tx_obs(), e); else n_pass++;
            n_chk++; if (state_o !== 3'd1 || tx_nreset_o !== 1'b1)
                $display("FAIL loss_state[%0d]: got state %0d txn %b want 1/1", i, state_o, tx_nreset_o); else n_pass++;
        end
        n_chk++; if (relock_cnt_o !== 16'(STATS)) $display("FAIL loss_relock: got %0d want %0d", relock_cnt_o, STATS); else n_pass++;
    endtask

    task automatic test_underrun();
        bit ok;
        w_t rxw[7], ex[7], e;
        bit vld[7], sig[7];
        bring_up(ok);
        n_chk++; if (!ok) $display("FAIL urun_bring_up: got timeout want FORWARD"); else n_pass++;
        rxw[0] = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 64'hC0DE, 8'hFF);  vld[0] = 1; ex[0] = rxw[0];
        rxw[1] = IDLE_W;                                              vld[1] = 0; ex[1] = ERR_W;
        rxw[2] = IDLE_W;                                              vld[2] = 0; ex[2] = IDLE_W;
        rxw[3] = mk(1'b1, 1'b0, 1'b1, 1'b0, 2'b10, 64'hF00D, 8'h03);  vld[3] = 1; ex[3] = rxw[3];
        rxw[4] = IDLE_W;                                              vld[4] = 0; ex[4] = ERR_W;
        rxw[5] = IDLE_W;                                              vld[5] = 0; ex[5] = IDLE_W;
        rxw[6] = IDLE_W;                                              vld[6] = 1; ex[6] = IDLE_W;
        for (int i = 0; i < 7; i++) sig[i] = (i != 6);
        for (int i = 0; i < 7; i++) begin
            drive_rx(rxw[i], vld[i]);
            rx_signal_v_i = sig[i];
            exp_q.push_back(ex[i]);
            step();
            e = exp_q.pop_front();
            n_chk++; if (tx_obs() !== e) $display("FAIL urun_word[%0d]: got %h want %h", i, tx_obs(), e); else n_pass++;
        end
        n_chk++; if (state_o !== 3'd1) $display("FAIL urun_loss_state: got %0d want 1", state_o); else n_pass++;
        n_chk++; if (drop_cnt_o !== 16'(2 * STATS)) $display("FAIL urun_drop: got %0d want %0d", drop_cnt_o, 2 * STATS); else n_pass++;
        n_chk++; if (relock_cnt_o !== 16'(STATS)) $display("FAIL urun_relock: got %0d want %0d", relock_cnt_o, STATS); else n_pass++;
    endtask

    task automatic test_serdes_loss();
        bit ok;
        w_t s, e;
        bring_up(ok);
        n_chk++; if (!ok) $display("FAIL sdl_bring_up: got timeout want FORWARD"); else n_pass++;
        s = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 64'h9999, 8'hFF);
        drive_rx(s, 1'b1); exp_q.push_back(s); step();
        e = exp_q.pop_front();
        n_chk++; if (tx_obs() !== e) $display("FAIL sdl_start: got %h want %h", tx_obs(), e); else n_pass++;
        // Signal loss at the same time must not win over the transceiver loss.
        serdes_ready_i = 1'b0; rx_signal_v_i = 1'b0;
        drive_rx(mk(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 64'hAAAA, 8'hFF), 1'b1);
        exp_q.push_back(IDLE_W);
        step();
        e = exp_q.pop_front();
        n_chk++; if (tx_obs() !== e) $display("FAIL sdl_word: got %h want %h", tx_obs(), e); else n_pass++;
        n_chk++; if (state_o !== 3'd0) $display("FAIL sdl_state: got %0d want 0", state_o); else n_pass++;
        n_chk++; if (tx_nreset_o !== 1'b0) $display("FAIL sdl_txn: got %b want 0", tx_nreset_o); else n_pass++;
        n_chk++; if (relock_cnt_o !== 16'd0) $display("FAIL sdl_relock: got %0d want 0", relock_cnt_o); else n_pass++;
    endtask

    task automatic test_async_reset();
        bit ok;
        w_t s;
        bring_up(ok);
        n_chk++; if (!ok) $display("FAIL arst_bring_up: got timeout want FORWARD"); else n_pass++;
        s = mk(1'b1, 1'b0, 1'b0, 1'b0, 2'b01, 64'hBBBB, 8'hFF);
        drive_rx(s, 1'b1);
        step();
        #2 nreset = 1'b0;
        #1;
        n_chk++; if (state_o !== 3'd0 || tx_nreset_o !== 1'b0)
            $display("FAIL arst_state: got state %0d txn %b want 0/0", state_o, tx_nreset_o); else n_pass++;
        n_chk++; if (tx_obs() !== IDLE_W) $display("FAIL arst_word: got %h want %h", tx_obs(), IDLE_W); else n_pass++;
        step();
        nreset = 1'b1;
    endtask

    initial begin
        test_reset();
        test_lock();
        test_idle_fill();
        test_fill_boundary();
        test_glitch();
        test_ready_drop(1'b0);
        test_ready_drop(1'b1);
        test_sig_loss();
        test_underrun();
        test_serdes_loss();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
